// File: rtl/matvec_seq.sv
// Sequential matrix-vector multiplier: one A column plus one B element per beat,
// accumulated in a skewed lane pipeline, then streamed out one row per handshake.
module matvec_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int K_MAX      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    signed_mode,
  input  logic                    abort,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  input  logic                    in_last,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACC_WIDTH-1:0]    res_data,
  output logic [$clog2(N)-1:0]    res_row,
  output logic                    res_ovf,
  output logic                    busy,
  output logic                    done,
  output logic                    len_err,
  output logic [1:0]              state_dbg
);
  localparam int RW = $clog2(N);
  localparam int CW = $clog2(K_MAX + 1);
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2, OUTPUT = 2'd3} state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          beat_cnt_reg;
  logic [RW-1:0]          drain_cnt_reg;
  logic [RW-1:0]          row_reg;
  logic                   signed_reg;
  logic                   len_err_reg;
  logic                   done_reg;
  logic [N-1:0]           vld_pipe;
  logic [DATA_WIDTH-1:0]  b_pipe [N];
  logic [ACC_WIDTH-1:0]   acc_arr [N];
  logic [N-1:0]           ovf_arr;

  logic start_go, accept, final_beat, last_row_xfer;

  assign start_go      = (state_reg == IDLE) && start;
  // abort beats a coincident handshake, so a beat is only taken when abort is low
  assign accept        = (state_reg == ACCUM) && in_valid && !abort;
  assign final_beat    = accept && (in_last || beat_cnt_reg == CW'(K_MAX - 1));
  assign last_row_xfer = (state_reg == OUTPUT) && res_ready && (row_reg == RW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (final_beat) state_next = DRAIN;
      DRAIN:   if (drain_cnt_reg == RW'(N - 1)) state_next = OUTPUT;
      OUTPUT:  if (last_row_xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && state_reg != IDLE) state_next = IDLE;
  end

  always_comb begin
    in_ready  = (state_reg == ACCUM);
    res_valid = (state_reg == OUTPUT);
    busy      = (state_reg != IDLE);
    state_dbg = state_reg;
    res_data  = acc_arr[row_reg];
    res_ovf   = ovf_arr[row_reg];
    res_row   = row_reg;
    done      = done_reg;
    len_err   = len_err_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      row_reg       <= '0;
      signed_reg    <= 1'b0;
      len_err_reg   <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg      <= last_row_xfer && !abort;
      drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + 1'b1 : '0;
      if (start_go) begin
        beat_cnt_reg <= '0;
        len_err_reg  <= 1'b0;
        signed_reg   <= signed_mode;
        row_reg      <= '0;
      end
      if (accept) begin
        beat_cnt_reg <= beat_cnt_reg + 1'b1;
        if (beat_cnt_reg == CW'(K_MAX - 1) && !in_last) len_err_reg <= 1'b1;
      end
      if (abort) row_reg <= '0;
      else if (state_reg == OUTPUT && res_ready)
        row_reg <= (row_reg == RW'(N - 1)) ? '0 : row_reg + 1'b1;
    end
  end

  // B and the valid tag travel one lane per cycle; a new run flushes stale beats.
  always_ff @(posedge clk) begin
    if (!rst_n || start_go) vld_pipe <= '0;
    else                    vld_pipe <= {vld_pipe[N-2:0], accept};
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] a_dly [gi+1];
      logic [ACC_WIDTH-1:0]  acc_q;
      logic                  ovf_q;
      logic [PW-1:0]         a_ext, b_ext, prod;
      logic [ACC_WIDTH+PW-1:0] prod_wide;
      logic [ACC_WIDTH-1:0]  addend;
      logic [ACC_WIDTH:0]    sum;
      logic                  add_ovf;

      always_ff @(posedge clk) begin
        if (!rst_n) b_pipe[gi] <= '0;
        else        b_pipe[gi] <= (gi == 0) ? in_b : b_pipe[(gi == 0) ? 0 : gi - 1];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int j = 0; j <= gi; j++) a_dly[j] <= '0;
        end else begin
          a_dly[0] <= in_a[gi*DATA_WIDTH +: DATA_WIDTH];
          for (int j = 1; j <= gi; j++) a_dly[j] <= a_dly[j-1];
        end
      end

      always_comb begin
        a_ext     = {{DATA_WIDTH{signed_reg & a_dly[gi][DATA_WIDTH-1]}}, a_dly[gi]};
        b_ext     = {{DATA_WIDTH{signed_reg & b_pipe[gi][DATA_WIDTH-1]}}, b_pipe[gi]};
        prod      = a_ext * b_ext;
        prod_wide = {{ACC_WIDTH{signed_reg & prod[PW-1]}}, prod};
        addend    = prod_wide[ACC_WIDTH-1:0];
        sum       = {1'b0, acc_q} + {1'b0, addend};
        add_ovf   = signed_reg ?
                    ((acc_q[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1])) :
                    sum[ACC_WIDTH];
      end

      always_ff @(posedge clk) begin
        if (!rst_n || start_go) begin
          acc_q <= '0;
          ovf_q <= 1'b0;
        end else if (vld_pipe[gi]) begin
          acc_q <= sum[ACC_WIDTH-1:0];
          if (add_ovf) ovf_q <= 1'b1;
        end
      end

      assign acc_arr[gi] = acc_q;
      assign ovf_arr[gi] = ovf_q;
    end
  endgenerate
endmodule

// File: tb/tb_matvec_seq.sv
// Randomized bench for matvec_seq: two instances (24-bit and 16-bit accumulators)
// share stimulus and are checked against a plain-arithmetic dot-product model.
module tb_matvec_seq;
  localparam int DW = 8;
  localparam int N  = 8;
  localparam int K  = 8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_mode = 1'b0, abort = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, res_ready = 1'b0;
  logic [N*DW-1:0] in_a = '0;
  logic [DW-1:0]   in_b = '0;

  logic in_ready, res_valid, res_ovf, busy, done, len_err;
  logic [23:0] res_data;
  logic [2:0]  res_row;
  logic [1:0]  state_dbg;
  logic in_ready_w, res_valid_w, res_ovf_w, busy_w, done_w, len_err_w;
  logic [15:0] res_data_w;
  logic [2:0]  res_row_w;
  logic [1:0]  state_dbg_w;

  int n_checks = 0, n_errors = 0, cyc = 0;
  int beat_a [K][N];
  int beat_b [K];
  longint exp24 [N], exp16 [N];
  bit ovf24 [N], ovf16 [N];

  matvec_seq #(.DATA_WIDTH(DW), .N(N), .ACC_WIDTH(24), .K_MAX(K)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_row(res_row),
    .res_ovf(res_ovf), .busy(busy), .done(done), .len_err(len_err), .state_dbg(state_dbg));

  matvec_seq #(.DATA_WIDTH(DW), .N(N), .ACC_WIDTH(16), .K_MAX(K)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .res_valid(res_valid_w), .res_ready(res_ready), .res_data(res_data_w), .res_row(res_row_w),
    .res_ovf(res_ovf_w), .busy(busy_w), .done(done_w), .len_err(len_err_w), .state_dbg(state_dbg_w));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Dot product of row i over nb beats, wrapped to w bits, with overflow judged per add.
  function automatic void row_model(input int i, input int nb, input bit sgn, input int w,
                                    output longint r, output bit o);
    longint m, acc, av, bv, p, as, s;
    m = longint'(1) << w;
    acc = 0;
    o = 1'b0;
    for (int k = 0; k < nb; k++) begin
      av = beat_a[k][i];
      bv = beat_b[k];
      if (sgn) begin
        if (av >= 128) av -= 256;
        if (bv >= 128) bv -= 256;
      end
      p = av * bv;
      if (!sgn) begin
        acc += p;
        if (acc >= m) begin o = 1'b1; acc -= m; end
      end else begin
        as = (acc >= m / 2) ? acc - m : acc;
        s  = as + p;
        if (s < -(m / 2) || s >= m / 2) o = 1'b1;
        acc = ((s % m) + m) % m;
      end
    end
    r = acc;
  endfunction

  task automatic compute(input int nb, input bit sgn);
    for (int i = 0; i < N; i++) begin
      row_model(i, nb, sgn, 24, exp24[i], ovf24[i]);
      row_model(i, nb, sgn, 16, exp16[i], ovf16[i]);
    end
  endtask

  // gap_pct < 0 alternates valid/bubble; stall_lo..stall_hi is res_ready low time per row.
  task automatic run(input string tag, input int nb, input bit use_last, input bit sgn,
                     input int gap_pct, input int stall_lo, input int stall_hi);
    int k, t_last, guard, stall;
    bit toggle;
    compute(nb, sgn);
    @(negedge clk);
    signed_mode = sgn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    signed_mode = ~sgn;
    check_eq({tag, ":busy"}, busy, 1);
    k = 0; t_last = 0; toggle = 1'b0;
    while (k < nb) begin
      if ((gap_pct < 0 && toggle) || (gap_pct > 0 && $urandom_range(99) < gap_pct)) begin
        in_valid = 1'b0;
        in_a = {$urandom, $urandom};
        in_b = DW'($urandom);
        toggle = 1'b0;
      end else begin
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) in_a[i*DW +: DW] = DW'(beat_a[k][i]);
        in_b = DW'(beat_b[k]);
        in_last = use_last && (k == nb - 1);
        if (!in_ready) check_eq({tag, ":in_ready"}, in_ready, 1);
        t_last = cyc;
        k++;
        toggle = 1'b1;
      end
      @(negedge clk);
    end
    in_last = 1'b0;
    in_valid = !use_last;
    in_a = '1;
    in_b = '1;
    check_eq({tag, ":ready_low"}, in_ready, 0);
    check_eq({tag, ":drain_state"}, state_dbg, 2);
    if (!use_last) check_eq({tag, ":len_err"}, len_err, 1);
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!res_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, ":latency"}, cyc - t_last, N + 1);
    for (int r = 0; r < N; r++) begin
      stall = $urandom_range(stall_hi, stall_lo);
      res_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        check_eq({tag, ":stall_data"}, res_data, exp24[r]);
        check_eq({tag, ":stall_row"}, res_row, r);
        @(negedge clk);
      end
      res_ready = 1'b1;
      check_eq({tag, ":valid"}, res_valid, 1);
      check_eq({tag, ":row"}, res_row, r);
      check_eq({tag, ":data24"}, res_data, exp24[r]);
      check_eq({tag, ":ovf24"}, res_ovf, ovf24[r]);
      check_eq({tag, ":data16"}, res_data_w, exp16[r]);
      check_eq({tag, ":ovf16"}, res_ovf_w, ovf16[r]);
      $display("%s row %0d data=%06h ovf=%0d data16=%04h ovf16=%0d", tag, r, res_data, res_ovf,
               res_data_w, res_ovf_w);
      @(negedge clk);
    end
    res_ready = 1'b0;
    check_eq({tag, ":done"}, done, 1);
    check_eq({tag, ":idle"}, state_dbg, 0);
    check_eq({tag, ":busy_off"}, busy, 0);
    @(negedge clk);
    check_eq({tag, ":done_pulse"}, done, 0);
  endtask

  task automatic load_const(input int av, input int bv);
    for (int k = 0; k < K; k++) begin
      beat_b[k] = bv;
      for (int i = 0; i < N; i++) beat_a[k][i] = av;
    end
  endtask

  task automatic load_basic();
    for (int k = 0; k < K; k++) begin
      beat_b[k] = k + 1;
      for (int i = 0; i < N; i++) beat_a[k][i] = i + 1;
    end
  endtask

  task automatic load_random();
    for (int k = 0; k < K; k++) begin
      beat_b[k] = $urandom_range(255);
      for (int i = 0; i < N; i++) beat_a[k][i] = $urandom_range(255);
    end
  endtask

  // Start a run, feed three beats, then cancel with abort or reset.
  task automatic cancel_run(input string tag, input bit use_reset);
    bit seen;
    load_basic();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) in_a[i*DW +: DW] = DW'(beat_a[k][i]);
      in_b = DW'(beat_b[k]);
      if (k == 3) begin
        if (use_reset) rst_n = 1'b0;
        else abort = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    abort = 1'b0;
    check_eq({tag, ":state"}, state_dbg, 0);
    check_eq({tag, ":busy"}, busy, 0);
    check_eq({tag, ":in_ready"}, in_ready, 0);
    if (use_reset) begin
      check_eq({tag, ":res_data"}, res_data, 0);
      check_eq({tag, ":res_ovf"}, res_ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;
    end
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      seen |= done | res_valid;
      @(negedge clk);
    end
    check_eq({tag, ":quiet"}, seen, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst:in_ready", in_ready, 0);
    check_eq("rst:res_valid", res_valid, 0);
    check_eq("rst:res_data", res_data, 0);
    check_eq("rst:res_row", res_row, 0);
    check_eq("rst:res_ovf", res_ovf, 0);
    check_eq("rst:busy", busy, 0);
    check_eq("rst:done", done, 0);
    check_eq("rst:len_err", len_err, 0);
    check_eq("rst:state", state_dbg, 0);
    rst_n = 1'b1;
    @(negedge clk);

    load_basic();          run("basic", 8, 1'b1, 1'b0, 0, 0, 0);
    load_const(8'hFF, 2);  run("signed", 8, 1'b1, 1'b1, 0, 0, 0);
    load_const(8'hFF, 2);  run("unsigned_ff", 8, 1'b1, 1'b0, 0, 0, 0);
    load_basic();          run("backpressure", 8, 1'b1, 1'b0, -1, 5, 5);
    load_const(8'hFF, 8'hFF); run("overflow", 8, 1'b1, 1'b0, 0, 0, 1);
    load_basic();          run("clean", 8, 1'b1, 1'b0, 0, 0, 0);
    load_random();         run("length", 8, 1'b0, 1'b0, 20, 0, 2);
    cancel_run("abort", 1'b0);
    cancel_run("reset", 1'b1);
    load_basic();          run("after_cancel", 8, 1'b1, 1'b0, 0, 0, 0);

    for (int t = 0; t < 15; t++) begin
      int nb;
      bit ul;
      nb = $urandom_range(K, 1);
      ul = (nb < K) ? 1'b1 : 1'($urandom_range(1));
      load_random();
      run($sformatf("rand%0d", t), nb, ul, 1'($urandom_range(1)), 30, 0, 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
